hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Second-generation pipeline hazard/flush controller for the 5-stage core (F, D, E, M, W).
- Generates a per-stage stall and bubble for each pipeline register.
- Handles four hazard sources:
  - load-use, with a configurable number of stall cycles;
  - branch/address redirect from E;
  - multi-cycle MDU operations in E;
  - data-memory wait states in M.
- Adds saturating stall and flush performance counters.

Parameters:
REG_ADDR_W, 5, register-index width
LS_INFO_W, 8, width of the load/store one-hot info bus; bits [7:3] = lb, lh, lw, lbu, lhu
LOAD_USE_STALL, 1, stall cycles per load-use hazard (1..7)
CNT_W, 32, performance counter width

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
execute_branch_fix_i  in  1  branch direction mispredict in E
execute_addr_fix_i  in  1  jump/branch target mispredict in E
decode_i_rs1  in  REG_ADDR_W  D-stage source 1
decode_i_rs2  in  REG_ADDR_W  D-stage source 2
decode_i_rs1_used  in  1  D instruction reads rs1
decode_i_rs2_used  in  1  D instruction reads rs2
regE_i_rd  in  REG_ADDR_W  E-stage destination
regE_load_store_info_i  in  LS_INFO_W  E-stage load/store one-hot
execute_i_mdu_start  in  1  multi-cycle mul/div present in E
mdu_i_done  in  1  MDU result valid this cycle
memory_i_dmem_req  in  1  M stage issuing a dmem access
dmem_i_ready  in  1  dmem accepts/returns this cycle
ctrl_o_stall  out  5  stall per register; index 0=F, 1=D, 2=E, 3=M, 4=W
ctrl_o_bubble  out  5  bubble per register, same indexing
ctrl_o_stall_cnt  out  CNT_W  cycles with any stall asserted
ctrl_o_flush_cnt  out  CNT_W  redirect events

Behaviour:
- FSM states: IDLE, LU_STALL, MDU_WAIT, MEM_WAIT.
  - Encoding: 2 bits; reset → IDLE.
  - Internal lu_cnt is 3 bits; reset → 0.
- Outputs are combinational from the state and the inputs.
- Reset: while rst=1, ctrl_o_stall=5'b00000 and ctrl_o_bubble=5'b11111 (flushes the pipe). Both counters → 0.
- Reset mid-operation aborts any wait; there is no carry-over.

Hazard terms:
- load_use = |regE_load_store_info_i[7:3] & regE_i_rd!=0 & ((rs1_used & rs1==rd) | (rs2_used & rs2==rd)).
  - x0 never hazards.
- redirect = execute_branch_fix_i | execute_addr_fix_i.
- mem_wait = memory_i_dmem_req & !dmem_i_ready.
- mdu_wait = (execute_i_mdu_start | state==MDU_WAIT) & !mdu_i_done.

Per-cycle output priority (highest first):
1. mem_wait:
   - stall = F, D, E, M; bubble = W.
   - Next state MEM_WAIT while the wait persists, else IDLE.
   - redirect and load_use are ignored; E is frozen and re-presents them.
2. mdu_wait:
   - stall = F, D, E; bubble = M.
   - Next state MDU_WAIT.
   - In the cycle mdu_i_done=1 there is no MDU stall; next state IDLE.
3. redirect:
   - bubble = D, E; no stall.
   - Flush counter +1.
   - Clears lu_cnt; next state IDLE (overrides LU_STALL).
4. load_use in IDLE, or state LU_STALL:
   - stall = F, D; bubble = E.
   - On entry from IDLE, lu_cnt ← LOAD_USE_STALL-1.
   - While in LU_STALL, lu_cnt decrements each cycle; the state exits to IDLE in the cycle lu_cnt==0 is consumed.
   - Total stall cycles = LOAD_USE_STALL exactly.
   - LOAD_USE_STALL=1 never enters LU_STALL.
5. Otherwise all outputs are 0.

Counters:
- Stall counter: +1 on any cycle with |ctrl_o_stall while rst=0.
- Both counters saturate at all-ones; there is no wrap.
- Counters are registered, so the count is visible the cycle after the event.

Simultaneous events:
- mem_wait and mdu_wait in the same cycle: MEM_WAIT wins. The MDU condition is re-evaluated after memory completes, because execute_i_mdu_start is still held.
- redirect during LU_STALL: the flush wins and the stall sequence is abandoned.

Decomposition:
- Add to define.v:
  - stage indices `STG_F..`STG_W;
  - FSM state encodings;
  - load-bit positions of the LS info bus.
- One sub-module, hazard_detect: combinational load_use compare, parameterised by REG_ADDR_W and LS_INFO_W.
- FSM, lu_cnt and counters stay in hazard_ctrl.

Test Plan:
- LOAD_USE_STALL=1, lw rd=5 in E, D rs1=5 used → one cycle of stall=00011, bubble=00100; then 0.
- LOAD_USE_STALL=3, same hazard → stall=00011 for exactly 3 cycles; stall_cnt reads 3.
- lw rd=0 with rs1=0, or rs2=5 with rs2_used=0 → no stall.
- execute_addr_fix_i pulse during the 2nd of 3 LU cycles → bubble=00110, stall=0 that cycle; then IDLE; flush_cnt +1.
- mdu_start with done after 4 cycles → stall=00111, bubble=01000 for 4 cycles; done cycle outputs 0.
- dmem_req with ready low for 2 cycles, overlapping mdu_start and branch_fix → stall=01111, bubble=10000 for 2 cycles, then the MDU wait begins; no flush counted during the wait.
- Assert rst mid MDU_WAIT → bubble=11111, counters 0; after reset state is IDLE.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard/flush controller:
//   - pipeline stage indices used to address the stall/bubble vectors
//   - FSM state encoding of the controller
//   - bit positions of the load opcodes inside the E-stage load/store info bus
//   - a small helper that builds a one-hot stage mask
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

   // Stage index into ctrl_o_stall / ctrl_o_bubble
   localparam int STG_F   = 0;
   localparam int STG_D   = 1;
   localparam int STG_E   = 2;
   localparam int STG_M   = 3;
   localparam int STG_W   = 4;
   localparam int NUM_STG = 5;

   // Load/store one-hot info bus: loads occupy bits [7:3]
   localparam int LS_LB_BIT     = 7;
   localparam int LS_LH_BIT     = 6;
   localparam int LS_LW_BIT     = 5;
   localparam int LS_LBU_BIT    = 4;
   localparam int LS_LHU_BIT    = 3;
   localparam int LS_LOAD_MSB   = LS_LB_BIT;
   localparam int LS_LOAD_LSB   = LS_LHU_BIT;

   // Controller FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MDU_WAIT = 2'd2,
      ST_MEM_WAIT = 2'd3
   } hz_state_e;

   // One-hot mask for a single stage
   function automatic logic [NUM_STG-1:0] stg_bit(input int idx);
      return NUM_STG'(1) << idx;
   endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use detector. Flags a hazard when the instruction in E is
// a load writing a non-zero register that the instruction in D reads.
// Ports:
//   rs1_i, rs2_i         D-stage source register indices
//   rs1_used_i, rs2_used_i  D instruction actually reads that source
//   rd_i                 E-stage destination register index
//   ls_info_i            E-stage load/store one-hot info
//   load_use_o           hazard present this cycle
// -----------------------------------------------------------------------------
module hazard_detect
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int LS_INFO_W  = 8
) (
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   input  logic                  rs1_used_i,
   input  logic                  rs2_used_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   input  logic [LS_INFO_W-1:0]  ls_info_i,
   output logic                  load_use_o
);

   logic [REG_ADDR_W-1:0] src_addr [2];
   logic [1:0]            src_used;
   logic [1:0]            src_match;
   logic                  is_load;
   logic                  rd_nonzero;
   logic                  unused_ls_bits;

   assign src_addr[0] = rs1_i;
   assign src_addr[1] = rs2_i;
   assign src_used    = {rs2_used_i, rs1_used_i};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign src_match[gi] = src_used[gi] && (src_addr[gi] == rd_i);
      end
   endgenerate

   assign is_load    = |ls_info_i[LS_LOAD_MSB:LS_LOAD_LSB];
   // x0 is hard-wired zero, so a load into it can never create a dependency
   assign rd_nonzero = |rd_i;
   assign load_use_o = is_load && rd_nonzero && (|src_match);

   // Store/other bits of the info bus carry no load-use meaning
   assign unused_ls_bits = ^ls_info_i;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard/flush controller for the 5-stage core (F, D, E, M, W).
// Produces per-pipeline-register stall and bubble strobes from four hazard
// sources (dmem wait, multi-cycle MDU, redirect from E, load-use) in fixed
// priority order, plus saturating stall-cycle and flush-event counters.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   execute_branch_fix_i          branch direction mispredict in E
//   execute_addr_fix_i            target mispredict in E
//   decode_i_rs1/rs2(_used)       D-stage sources
//   regE_i_rd                     E-stage destination
//   regE_load_store_info_i        E-stage load/store one-hot
//   execute_i_mdu_start           MDU op present in E
//   mdu_i_done                    MDU result valid
//   memory_i_dmem_req             M stage dmem access
//   dmem_i_ready                  dmem handshake
//   ctrl_o_stall / ctrl_o_bubble  per register strobes, index 0=F .. 4=W
//   ctrl_o_stall_cnt              cycles with any stall
//   ctrl_o_flush_cnt              redirect events
// -----------------------------------------------------------------------------
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W     = 5,
   parameter int LS_INFO_W      = 8,
   parameter int LOAD_USE_STALL = 1,
   parameter int CNT_W          = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  execute_branch_fix_i,
   input  logic                  execute_addr_fix_i,
   input  logic [REG_ADDR_W-1:0] decode_i_rs1,
   input  logic [REG_ADDR_W-1:0] decode_i_rs2,
   input  logic                  decode_i_rs1_used,
   input  logic                  decode_i_rs2_used,
   input  logic [REG_ADDR_W-1:0] regE_i_rd,
   input  logic [LS_INFO_W-1:0]  regE_load_store_info_i,
   input  logic                  execute_i_mdu_start,
   input  logic                  mdu_i_done,
   input  logic                  memory_i_dmem_req,
   input  logic                  dmem_i_ready,
   output logic [NUM_STG-1:0]    ctrl_o_stall,
   output logic [NUM_STG-1:0]    ctrl_o_bubble,
   output logic [CNT_W-1:0]      ctrl_o_stall_cnt,
   output logic [CNT_W-1:0]      ctrl_o_flush_cnt
);

   // Remaining load-use stall cycles after the entry cycle
   localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_STALL - 1);

   localparam logic [NUM_STG-1:0] STALL_MEM = stg_bit(STG_F) | stg_bit(STG_D) |
                                              stg_bit(STG_E) | stg_bit(STG_M);
   localparam logic [NUM_STG-1:0] BUB_MEM   = stg_bit(STG_W);
   localparam logic [NUM_STG-1:0] STALL_MDU = stg_bit(STG_F) | stg_bit(STG_D) |
                                              stg_bit(STG_E);
   localparam logic [NUM_STG-1:0] BUB_MDU   = stg_bit(STG_M);
   localparam logic [NUM_STG-1:0] BUB_REDIR = stg_bit(STG_D) | stg_bit(STG_E);
   localparam logic [NUM_STG-1:0] STALL_LU  = stg_bit(STG_F) | stg_bit(STG_D);
   localparam logic [NUM_STG-1:0] BUB_LU    = stg_bit(STG_E);

   hz_state_e            state_q, state_d;
   logic [2:0]           lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
   logic [NUM_STG-1:0]   stall_c, bubble_c;
   logic                 flush_evt;

   logic                 load_use;
   logic                 redirect;
   logic                 mem_wait;
   logic                 mdu_wait;

   hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W),
      .LS_INFO_W  (LS_INFO_W)
   ) u_detect (
      .rs1_i      (decode_i_rs1),
      .rs2_i      (decode_i_rs2),
      .rs1_used_i (decode_i_rs1_used),
      .rs2_used_i (decode_i_rs2_used),
      .rd_i       (regE_i_rd),
      .ls_info_i  (regE_load_store_info_i),
      .load_use_o (load_use)
   );

   assign redirect = execute_branch_fix_i | execute_addr_fix_i;
   assign mem_wait = memory_i_dmem_req & ~dmem_i_ready;
   // Once waiting, the MDU keeps the pipe frozen even if start is not re-driven
   assign mdu_wait = (execute_i_mdu_start | (state_q == ST_MDU_WAIT)) & ~mdu_i_done;

   always_comb begin
      state_d   = ST_IDLE;
      lu_cnt_d  = lu_cnt_q;
      stall_c   = '0;
      bubble_c  = '0;
      flush_evt = 1'b0;

      if (mem_wait) begin
         // E is frozen, so any redirect/load-use it carries is re-presented later
         stall_c  = STALL_MEM;
         bubble_c = BUB_MEM;
         state_d  = ST_MEM_WAIT;
      end else if (mdu_wait) begin
         stall_c  = STALL_MDU;
         bubble_c = BUB_MDU;
         state_d  = ST_MDU_WAIT;
      end else if (redirect) begin
         // Flush abandons any load-use sequence in progress
         bubble_c  = BUB_REDIR;
         flush_evt = 1'b1;
         lu_cnt_d  = 3'd0;
         state_d   = ST_IDLE;
      end else if (state_q == ST_LU_STALL) begin
         stall_c  = STALL_LU;
         bubble_c = BUB_LU;
         lu_cnt_d = (lu_cnt_q == 3'd0) ? 3'd0 : lu_cnt_q - 3'd1;
         // Leave in the cycle that consumes the last remaining count
         state_d  = (lu_cnt_q <= 3'd1) ? ST_IDLE : ST_LU_STALL;
      end else if (load_use) begin
         stall_c  = STALL_LU;
         bubble_c = BUB_LU;
         lu_cnt_d = LU_RELOAD;
         state_d  = (LU_RELOAD == 3'd0) ? ST_IDLE : ST_LU_STALL;
      end
   end

   // Saturating counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((|stall_c) && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lu_cnt_q    <= 3'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         lu_cnt_q    <= lu_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Reset flushes every pipeline register and releases all stalls
   assign ctrl_o_stall     = rst ? '0 : stall_c;
   assign ctrl_o_bubble    = rst ? '1 : bubble_c;
   assign ctrl_o_stall_cnt = stall_cnt_q;
   assign ctrl_o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       branch_fix, addr_fix;
   logic [4:0] rs1, rs2, rd;
   logic       rs1_used, rs2_used;
   logic [7:0] ls_info;
   logic       mdu_start, mdu_done, dmem_req, dmem_ready;

   logic [4:0]  stall_o   [2];
   logic [4:0]  bubble_o  [2];
   logic [31:0] scnt_o    [2];
   logic [31:0] fcnt_o    [2];

   int errors = 0;
   int checks = 0;

   // Reference model state: one slot per instance
   int          lu_n      [2] = '{1, 3};
   int          lu_left   [2];
   bit          mdu_busy  [2];
   int unsigned m_scnt    [2];
   int unsigned m_fcnt    [2];
   bit          cnt_known = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_ADDR_W(5), .LS_INFO_W(8), .LOAD_USE_STALL(1), .CNT_W(32)) u_dut1 (
      .clk(clk), .rst(rst),
      .execute_branch_fix_i(branch_fix), .execute_addr_fix_i(addr_fix),
      .decode_i_rs1(rs1), .decode_i_rs2(rs2),
      .decode_i_rs1_used(rs1_used), .decode_i_rs2_used(rs2_used),
      .regE_i_rd(rd), .regE_load_store_info_i(ls_info),
      .execute_i_mdu_start(mdu_start), .mdu_i_done(mdu_done),
      .memory_i_dmem_req(dmem_req), .dmem_i_ready(dmem_ready),
      .ctrl_o_stall(stall_o[0]), .ctrl_o_bubble(bubble_o[0]),
      .ctrl_o_stall_cnt(scnt_o[0]), .ctrl_o_flush_cnt(fcnt_o[0])
   );

   hazard_ctrl #(.REG_ADDR_W(5), .LS_INFO_W(8), .LOAD_USE_STALL(3), .CNT_W(32)) u_dut3 (
      .clk(clk), .rst(rst),
      .execute_branch_fix_i(branch_fix), .execute_addr_fix_i(addr_fix),
      .decode_i_rs1(rs1), .decode_i_rs2(rs2),
      .decode_i_rs1_used(rs1_used), .decode_i_rs2_used(rs2_used),
      .regE_i_rd(rd), .regE_load_store_info_i(ls_info),
      .execute_i_mdu_start(mdu_start), .mdu_i_done(mdu_done),
      .memory_i_dmem_req(dmem_req), .dmem_i_ready(dmem_ready),
      .ctrl_o_stall(stall_o[1]), .ctrl_o_bubble(bubble_o[1]),
      .ctrl_o_stall_cnt(scnt_o[1]), .ctrl_o_flush_cnt(fcnt_o[1])
   );

   task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[LUS=%0d]: got %0h expected %0h", tag, lu_n[k], obs, exp);
      end
   endtask

   task automatic idle_inputs();
      rst = 0; branch_fix = 0; addr_fix = 0;
      rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0; ls_info = 0;
      mdu_start = 0; mdu_done = 0; dmem_req = 0; dmem_ready = 1;
   endtask

   // One clock: compare outputs at the falling edge, then advance the model
   task automatic tick();
      bit         is_load, hz, mw, redir;
      logic [4:0] es, eb;
      bit         fl;
      @(negedge clk);
      is_load = (ls_info[7:3] != 5'b0);
      hz      = is_load && (rd != 0) &&
                ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
      mw      = dmem_req && !dmem_ready;
      redir   = branch_fix || addr_fix;
      for (int k = 0; k < 2; k++) begin
         es = 5'b00000; eb = 5'b00000; fl = 0;
         if (rst) begin
            eb = 5'b11111;
         end else if (mw) begin
            es = 5'b01111; eb = 5'b10000;
            mdu_busy[k] = 0; lu_left[k] = 0;
         end else if ((mdu_start || mdu_busy[k]) && !mdu_done) begin
            es = 5'b00111; eb = 5'b01000;
            mdu_busy[k] = 1; lu_left[k] = 0;
         end else begin
            mdu_busy[k] = 0;
            if (redir) begin
               eb = 5'b00110; fl = 1; lu_left[k] = 0;
            end else if (lu_left[k] > 0) begin
               es = 5'b00011; eb = 5'b00100; lu_left[k]--;
            end else if (hz) begin
               es = 5'b00011; eb = 5'b00100; lu_left[k] = lu_n[k] - 1;
            end
         end
         check("stall", k, {27'b0, stall_o[k]}, {27'b0, es});
         check("bubble", k, {27'b0, bubble_o[k]}, {27'b0, eb});
         if (cnt_known) begin
            check("stall_cnt", k, scnt_o[k], m_scnt[k]);
            check("flush_cnt", k, fcnt_o[k], m_fcnt[k]);
         end
         if (rst) begin
            m_scnt[k] = 0; m_fcnt[k] = 0; lu_left[k] = 0; mdu_busy[k] = 0;
         end else begin
            if (es != 0 && m_scnt[k] != 32'hFFFF_FFFF) m_scnt[k]++;
            if (fl && m_fcnt[k] != 32'hFFFF_FFFF) m_fcnt[k]++;
         end
      end
      if (rst) cnt_known = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic set_lw_hazard();
      ls_info = 8'h20; rd = 5; rs1 = 5; rs1_used = 1;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      tick(); tick();
      idle_inputs();
      tick();

      // Load-use: lw x5 in E, D reads x5
      set_lw_hazard(); tick();
      idle_inputs(); repeat (4) tick();

      // No hazard through x0, nor through an unused rs2
      ls_info = 8'h20; rd = 0; rs1 = 0; rs1_used = 1; tick();
      idle_inputs();
      ls_info = 8'h20; rd = 5; rs2 = 5; rs2_used = 0; tick();
      idle_inputs(); tick();

      // Redirect during the second load-use cycle
      set_lw_hazard(); tick();
      idle_inputs(); addr_fix = 1; tick();
      idle_inputs(); repeat (3) tick();

      // MDU op finishing after 4 wait cycles
      mdu_start = 1; repeat (4) tick();
      mdu_done = 1; tick();
      idle_inputs(); tick();

      // dmem wait overlapping an MDU op and a branch fix
      dmem_req = 1; dmem_ready = 0; mdu_start = 1; branch_fix = 1;
      repeat (2) tick();
      dmem_ready = 1; branch_fix = 0; repeat (2) tick();
      mdu_done = 1; tick();
      idle_inputs(); tick();

      // Reset in the middle of an MDU wait
      mdu_start = 1; repeat (2) tick();
      mdu_start = 0; tick();
      rst = 1; repeat (2) tick();
      idle_inputs(); repeat (2) tick();

      // Randomised traffic
      for (int n = 0; n < 500; n++) begin
         rst        = ($urandom_range(0, 99) == 0);
         branch_fix = ($urandom_range(0, 15) == 0);
         addr_fix   = ($urandom_range(0, 15) == 0);
         rd         = 5'($urandom_range(0, 3));
         rs1        = 5'($urandom_range(0, 3));
         rs2        = 5'($urandom_range(0, 3));
         rs1_used   = 1'($urandom_range(0, 1));
         rs2_used   = 1'($urandom_range(0, 1));
         ls_info    = $urandom_range(0, 1) ? (8'h80 >> $urandom_range(0, 4))
                                           : 8'($urandom_range(0, 7));
         mdu_start  = ($urandom_range(0, 5) == 0);
         mdu_done   = ($urandom_range(0, 2) == 0);
         dmem_req   = ($urandom_range(0, 3) == 0);
         dmem_ready = ($urandom_range(0, 9) < 6);
         tick();
      end
      idle_inputs(); repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
